// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: write-back source codes, the hardwired-zero
// register index and the default performance-counter width.
package pipe_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_IMM  = 2'd2,
        WB_LINK = 2'd3
    } wb_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/perf_counter.sv
// Free-running enable counter with synchronous clear; wraps modulo 2^W.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/stage_wb.sv
// Write-back stage: MEM/WB pipeline register, register-file write port,
// one-deep last-write shadow and retire/stall performance counters.
module stage_wb
    import pipe_pkg::*;
#(
    parameter int         CNT_W    = CNT_W_DEF,
    parameter logic [1:0] LINK_SEL = 2'd3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_MEM,
    input  logic [31:0]      ALUres_MEM,
    input  logic [31:0]      MemRd,
    input  logic [31:0]      ExtImm_MEM,
    input  logic [31:0]      PC8_MEM,
    input  logic             RegWrite_MEM,
    input  logic [1:0]       MemtoReg_MEM,
    input  logic [4:0]       WriteReg_MEM,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             valid_WB,
    output logic [31:0]      ALUres_WB,
    output logic [31:0]      MemRd_WB,
    output logic [31:0]      ExtImm_WB,
    output logic             RegWrite_WB,
    output logic [4:0]       WriteReg_WB,
    output logic [1:0]       MemtoReg_WB,
    output logic             RegWe,
    output logic [4:0]       RegWa,
    output logic [31:0]      RegWd,
    output logic             Last_we,
    output logic [4:0]       Last_wa,
    output logic [31:0]      Last_wd,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic        r_valid;
    logic [31:0] r_alu;
    logic [31:0] r_memrd;
    logic [31:0] r_imm;
    logic [31:0] r_pc8;
    logic        r_regwrite;
    logic [1:0]  r_sel;
    logic [4:0]  r_wr;
    logic        r_last_we;
    logic [4:0]  r_last_wa;
    logic [31:0] r_last_wd;

    logic        w_capture;
    logic        w_retire;
    logic        w_we;
    logic [31:0] w_wd;

    // A stalled instruction is only taken on the edge where the stall drops,
    // so it enters WB exactly once; MemRd is ignored while stalled.
    assign w_capture = !flush && !mem_stall;
    assign w_retire  = w_capture && valid_MEM;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_alu      <= '0;
            r_memrd    <= '0;
            r_imm      <= '0;
            r_pc8      <= '0;
            r_regwrite <= 1'b0;
            r_sel      <= '0;
            r_wr       <= '0;
            r_last_we  <= 1'b0;
            r_last_wa  <= '0;
            r_last_wd  <= '0;
        end else begin
            r_valid   <= w_retire;
            r_last_we <= w_we;
            r_last_wa <= r_wr;
            r_last_wd <= w_wd;
            if (w_capture) begin
                r_alu      <= ALUres_MEM;
                r_memrd    <= MemRd;
                r_imm      <= ExtImm_MEM;
                r_pc8      <= PC8_MEM;
                r_regwrite <= RegWrite_MEM;
                r_sel      <= MemtoReg_MEM;
                r_wr       <= WriteReg_MEM;
            end
        end
    end

    always_comb begin
        w_wd = r_alu;
        if (r_sel == LINK_SEL) begin
            w_wd = r_pc8;
        end else begin
            case (r_sel)
                WB_MEM:  w_wd = r_memrd;
                WB_IMM:  w_wd = r_imm;
                WB_LINK: w_wd = r_pc8;
                default: w_wd = r_alu;
            endcase
        end
    end

    assign w_we = r_valid && r_regwrite && (r_wr != REG_ZERO);

    perf_counter #(.W(CNT_W)) u_retire_cnt (
        .clk (clk),
        .clr (rst),
        .en  (w_retire),
        .cnt (retire_cnt)
    );

    perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .en  (mem_stall),
        .cnt (stall_cnt)
    );

    assign valid_WB    = r_valid;
    assign ALUres_WB   = r_alu;
    assign MemRd_WB    = r_memrd;
    assign ExtImm_WB   = r_imm;
    assign RegWrite_WB = r_regwrite && r_valid;
    assign WriteReg_WB = r_wr;
    assign MemtoReg_WB = r_sel;
    assign RegWe       = w_we;
    assign RegWa       = r_wr;
    assign RegWd       = w_wd;
    assign Last_we     = r_last_we;
    assign Last_wa     = r_last_wa;
    assign Last_wd     = r_last_wd;

endmodule

// File: tb/tb_stage_wb.sv
// Self-checking bench for stage_wb: directed vector table, multi-cycle corner
// sequences and random traffic against a slot-level reference model.
module tb_stage_wb;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_MEM;
    logic [31:0]   ALUres_MEM, MemRd, ExtImm_MEM, PC8_MEM;
    logic          RegWrite_MEM;
    logic [1:0]    MemtoReg_MEM;
    logic [4:0]    WriteReg_MEM;
    logic          mem_stall, flush;
    logic          valid_WB;
    logic [31:0]   ALUres_WB, MemRd_WB, ExtImm_WB;
    logic          RegWrite_WB;
    logic [4:0]    WriteReg_WB;
    logic [1:0]    MemtoReg_WB;
    logic          RegWe;
    logic [4:0]    RegWa;
    logic [31:0]   RegWd;
    logic          Last_we;
    logic [4:0]    Last_wa;
    logic [31:0]   Last_wd;
    logic [CW-1:0] retire_cnt, stall_cnt;

    always #5 clk = ~clk;

    stage_wb #(.CNT_W(CW), .LINK_SEL(2'd3)) dut (
        .clk(clk), .rst(rst), .valid_MEM(valid_MEM), .ALUres_MEM(ALUres_MEM),
        .MemRd(MemRd), .ExtImm_MEM(ExtImm_MEM), .PC8_MEM(PC8_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .WriteReg_MEM(WriteReg_MEM), .mem_stall(mem_stall), .flush(flush),
        .valid_WB(valid_WB), .ALUres_WB(ALUres_WB), .MemRd_WB(MemRd_WB),
        .ExtImm_WB(ExtImm_WB), .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB),
        .MemtoReg_WB(MemtoReg_WB), .RegWe(RegWe), .RegWa(RegWa), .RegWd(RegWd),
        .Last_we(Last_we), .Last_wa(Last_wa), .Last_wd(Last_wd),
        .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: contents of the WB slot, the shadow and the counters.
    logic        m_valid, m_rw;
    logic [31:0] m_src [4];   // indexed by write-back select: alu, mem, imm, link
    logic [1:0]  m_sel;
    logic [4:0]  m_wr;
    logic        m_lwe;
    logic [4:0]  m_lwa;
    logic [31:0] m_lwd;
    int          m_ret, m_stl;

    function automatic logic exp_we();
        return m_valid && m_rw && (m_wr != 5'd0);
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_sel = 0; m_wr = 0;
        for (int i = 0; i < 4; i++) m_src[i] = 0;
        m_lwe = 0; m_lwa = 0; m_lwd = 0; m_ret = 0; m_stl = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
            return;
        end
        m_lwe = exp_we();
        m_lwa = m_wr;
        m_lwd = m_src[m_sel];
        if (mem_stall) m_stl = (m_stl + 1) % (1 << CW);
        if (flush || mem_stall) begin
            m_valid = 0;
        end else begin
            m_valid  = valid_MEM;
            m_rw     = RegWrite_MEM;
            m_sel    = MemtoReg_MEM;
            m_wr     = WriteReg_MEM;
            m_src[0] = ALUres_MEM;
            m_src[1] = MemRd;
            m_src[2] = ExtImm_MEM;
            m_src[3] = PC8_MEM;
            if (valid_MEM) m_ret = (m_ret + 1) % (1 << CW);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_all();
        chk("valid_WB",    32'(valid_WB),    32'(m_valid));
        chk("ALUres_WB",   ALUres_WB,        m_src[0]);
        chk("MemRd_WB",    MemRd_WB,         m_src[1]);
        chk("ExtImm_WB",   ExtImm_WB,        m_src[2]);
        chk("RegWrite_WB", 32'(RegWrite_WB), 32'(m_valid && m_rw));
        chk("WriteReg_WB", 32'(WriteReg_WB), 32'(m_wr));
        chk("MemtoReg_WB", 32'(MemtoReg_WB), 32'(m_sel));
        chk("RegWe",       32'(RegWe),       32'(exp_we()));
        chk("RegWa",       32'(RegWa),       32'(m_wr));
        chk("RegWd",       RegWd,            m_src[m_sel]);
        chk("Last_we",     32'(Last_we),     32'(m_lwe));
        chk("Last_wa",     32'(Last_wa),     32'(m_lwa));
        chk("Last_wd",     Last_wd,          m_lwd);
        chk("retire_cnt",  32'(retire_cnt),  32'(m_ret));
        chk("stall_cnt",   32'(stall_cnt),   32'(m_stl));
    endtask

    // One clock: inputs already set; update model at the edge, check at negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mrd,
                         input logic [31:0] imm, input logic [31:0] pc8, input logic rw,
                         input logic [1:0] sel, input logic [4:0] wr,
                         input logic stl, input logic fl);
        valid_MEM = v; ALUres_MEM = alu; MemRd = mrd; ExtImm_MEM = imm; PC8_MEM = pc8;
        RegWrite_MEM = rw; MemtoReg_MEM = sel; WriteReg_MEM = wr; mem_stall = stl; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic        v;
        logic [31:0] alu, mrd, imm, pc8;
        logic        rw;
        logic [1:0]  sel;
        logic [4:0]  wr;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs [7];
    logic [31:0] saved;
    int          base_ret, base_stl;

    initial begin
        vecs[0] = '{1, 32'h10, 32'hDEADBEEF, 32'h1, 32'h8, 1, 2'd1, 5'd8,  1, 5'd8,  32'hDEADBEEF};
        vecs[1] = '{1, 32'h20, 32'h1111, 32'h2, 32'h00400008, 1, 2'd3, 5'd31, 1, 5'd31, 32'h00400008};
        vecs[2] = '{1, 32'h5, 32'h2222, 32'h3, 32'h10, 1, 2'd0, 5'd0,  0, 5'd0,  32'h5};
        vecs[3] = '{1, 32'h6, 32'h3333, 32'hABCD0000, 32'h14, 1, 2'd2, 5'd5, 1, 5'd5, 32'hABCD0000};
        vecs[4] = '{1, 32'h77, 32'h4444, 32'h4, 32'h18, 1, 2'd0, 5'd9,  1, 5'd9,  32'h77};
        vecs[5] = '{0, 32'h88, 32'h5555, 32'h5, 32'h1C, 1, 2'd0, 5'd10, 0, 5'd10, 32'h88};
        vecs[6] = '{1, 32'h99, 32'h6666, 32'h6, 32'h20, 0, 2'd1, 5'd11, 0, 5'd11, 32'h6666};

        model_clear();
        idle();
        rst = 1;
        cycle();
        cycle();
        rst = 0;

        // Directed vector table, one instruction per cycle without stalls
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v, vecs[i].alu, vecs[i].mrd, vecs[i].imm, vecs[i].pc8,
                  vecs[i].rw, vecs[i].sel, vecs[i].wr, 0, 0);
            cycle();
            chk("vec_RegWe", 32'(RegWe), 32'(vecs[i].e_we));
            chk("vec_RegWa", 32'(RegWa), 32'(vecs[i].e_wa));
            chk("vec_RegWd", RegWd, vecs[i].e_wd);
            if (i == 0) chk("lw_retire", 32'(retire_cnt), 32'd1);
            if (i == 2) chk("r0_RegWrite_WB", 32'(RegWrite_WB), 32'd1);
        end
        // Shadow after jal is observed one cycle later
        idle();
        drive(1, 32'h20, 32'h1111, 32'h2, 32'h00400008, 1, 2'd3, 5'd31, 0, 0);
        cycle();
        idle();
        cycle();
        chk("jal_Last_we", 32'(Last_we), 32'd1);
        chk("jal_Last_wa", 32'(Last_wa), 32'd31);
        chk("jal_Last_wd", Last_wd, 32'h00400008);

        // Load held for three stall cycles with garbage data, then released
        base_ret = int'(retire_cnt);
        base_stl = int'(stall_cnt);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h40, 32'h0BAD, 0, 0, 1, 2'd1, 5'd12, 1, 0);
            cycle();
            chk("stall_bubble", 32'(valid_WB), 32'd0);
        end
        drive(1, 32'h40, 32'h1234, 0, 0, 1, 2'd1, 5'd12, 0, 0);
        cycle();
        chk("stall_we",     32'(RegWe), 32'd1);
        chk("stall_wd",     RegWd, 32'h1234);
        chk("stall_cnt3",   32'(stall_cnt), 32'((base_stl + 3) % 16));
        chk("stall_retire", 32'(retire_cnt), 32'((base_ret + 1) % 16));
        idle();
        cycle();
        chk("no_double_write", 32'(RegWe), 32'd0);

        // flush together with stall while a lui sits in MEM
        drive(1, 0, 0, 32'h0000BEEF, 0, 1, 2'd2, 5'd3, 0, 0);
        cycle();
        saved    = ExtImm_WB;
        base_stl = int'(stall_cnt);
        drive(1, 0, 0, 32'hABCD0000, 0, 1, 2'd2, 5'd4, 1, 1);
        cycle();
        chk("fs_RegWe",  32'(RegWe), 32'd0);
        chk("fs_ExtImm", ExtImm_WB, 32'h0000BEEF);
        chk("fs_stall",  32'(stall_cnt), 32'((base_stl + 1) % 16));

        // Reset in the middle of a stall, then a normal capture
        drive(1, 32'h50, 32'h0BAD, 0, 0, 1, 2'd1, 5'd13, 1, 0);
        cycle();
        rst = 1;
        cycle();
        chk("rst_mid_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 0;
        drive(1, 32'h50, 32'h5678, 0, 0, 1, 2'd1, 5'd13, 0, 0);
        cycle();
        chk("post_rst_wd", RegWd, 32'h5678);

        // Retire counter wrap at CNT_W=4, then reset clears everything
        rst = 1;
        idle();
        cycle();
        rst = 0;
        drive(1, 32'h1, 0, 0, 0, 1, 2'd0, 5'd1, 0, 0);
        for (int i = 0; i < 15; i++) cycle();
        chk("retire_15", 32'(retire_cnt), 32'd15);
        cycle();
        chk("retire_wrap", 32'(retire_cnt), 32'd0);
        rst = 1;
        cycle();
        chk("rst_valid", 32'(valid_WB), 32'd0);
        chk("rst_RegWe", 32'(RegWe), 32'd0);
        chk("rst_Last",  Last_wd, 32'd0);
        rst = 0;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
- Write-back stage of the 7-stage MIPS pipeline, directly downstream of the MEM stage.
- Contains the MEM/WB pipeline register, which captures the data-cache read data and the MEM-stage results.
- Handles `mem_stall` by inserting bubbles. Selects register-file write data. Provides the `*_WB` forwarding sources consumed by MEM and EX.
- Keeps a one-deep "last write-back" shadow for the register-file write/read hazard, plus retire and stall performance counters.

Parameters:
- `CNT_W`, 32, width of the performance counters.
- `LINK_SEL`, 2'd3, `MemtoReg` code that selects the link address (PC+8).

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `valid_MEM` in 1: MEM stage holds a live instruction.
- `ALUres_MEM` in 32: ALU result / address.
- `MemRd` in 32: DCache read data, combinational, meaningful only when `mem_stall`=0.
- `ExtImm_MEM` in 32: extended immediate (lui path).
- `PC8_MEM` in 32: link address.
- `RegWrite_MEM` in 1: instruction writes the register file.
- `MemtoReg_MEM` in 2: write-back source select.
- `WriteReg_MEM` in 5: destination register.
- `mem_stall` in 1: DCache miss; MEM does not advance this cycle.
- `flush` in 1: kill the instruction currently in MEM.
- `valid_WB` out 1: WB register holds a live instruction.
- `ALUres_WB` out 32: registered ALU result (forwarding source).
- `MemRd_WB` out 32: registered load data (forwarding source).
- `ExtImm_WB` out 32: registered immediate (forwarding source).
- `RegWrite_WB` out 1: `RegWrite` AND `valid_WB`.
- `WriteReg_WB` out 5: registered destination register.
- `MemtoReg_WB` out 2: registered select.
- `RegWe` out 1: register-file write enable.
- `RegWa` out 5: register-file write address.
- `RegWd` out 32: register-file write data.
- `Last_we` out 1: previous cycle's effective write enable.
- `Last_wa` out 5: previous cycle's write address.
- `Last_wd` out 32: previous cycle's write data.
- `retire_cnt` out `CNT_W`: instructions retired.
- `stall_cnt` out `CNT_W`: cycles with `mem_stall`=1.

Behaviour:
- Reset: every registered output returns to 0 on the first `clk` edge with `rst`=1. This covers `valid_WB`, the data/select/address registers, `Last_*`, and both counters. `RegWe`=0 follows.
- Per-edge update priority: `rst` > `flush` > `mem_stall` > capture.
  - `flush`=1: `valid_WB`←0. Data fields hold their previous values. `flush` together with `mem_stall` also gives a bubble.
  - `mem_stall`=1: `valid_WB`←0, a bubble. Data fields hold, so the forwarding values stay stable. `MemRd` is not sampled.
  - Otherwise: all fields ←MEM inputs, `valid_WB`←`valid_MEM`, `MemRd_WB`←`MemRd`.
- An instruction stalled in MEM reaches WB exactly once, on the edge where `mem_stall` falls. It is never written twice.
- Latency: one cycle from MEM to WB. `RegWd`/`RegWe` are combinational from the WB register, so the register file writes at the end of the WB cycle.
- `RegWd` select on `MemtoReg_WB`:
  - 0: `ALUres_WB`
  - 1: `MemRd_WB`
  - 2: `ExtImm_WB`
  - `LINK_SEL`: registered `PC8`
- `RegWe` = `valid_WB` & `RegWrite` & (`WriteReg_WB` != 0). Writes to r0 are suppressed, which also covers a jal bubble targeting r0.
- `RegWa` = `WriteReg_WB`.
- Shadow: every cycle `Last_we`←`RegWe`, `Last_wa`←`RegWa`, `Last_wd`←`RegWd`. A bubble cycle therefore gives `Last_we`=0.
- `retire_cnt` increments when `valid_WB`=1 on an edge (not flushed, not a bubble). It wraps modulo 2^`CNT_W`.
- `stall_cnt` increments on every edge with `mem_stall`=1 and `rst`=0. It wraps. A flush does not suppress it.
- Reset mid-stall: state clears. After release, the next non-stalled edge captures normally.

Decomposition:
- Shared package `pipe_pkg`:
  - `MemtoReg` codes: `WB_ALU`=0, `WB_MEM`=1, `WB_IMM`=2, `WB_LINK`=3.
  - `REG_ZERO`=5'd0.
  - `CNT_W` default.
- One sub-module, `perf_counter`, instantiated twice. It is a parametrised-width enable counter with synchronous clear and wrap.

Test Plan:
- Reset then lw: `ALUres_MEM`=0x10, `MemRd`=0xDEADBEEF, `MemtoReg`=1, `WriteReg`=8, `RegWrite`=1, no stall. Next cycle requires `RegWe`=1, `RegWa`=8, `RegWd`=0xDEADBEEF, `retire_cnt`=1.
- Load with 3-cycle `mem_stall`, `MemRd` garbage (0x0BAD) while stalled, then 0x1234. Requires `valid_WB`=0 for 3 cycles, then exactly one write of 0x1234, `stall_cnt`=3, `retire_cnt`+1.
- jal: `MemtoReg`=3, `PC8`=0x00400008, `WriteReg`=31. Requires `RegWd`=0x00400008. Next cycle `Last_we`=1, `Last_wa`=31, `Last_wd`=0x00400008.
- addu with `WriteReg`=0, `RegWrite`=1, `ALUres`=5. Requires `RegWe`=0, `RegWrite_WB`=1, `retire_cnt` increments.
- `flush` and `mem_stall` asserted together for one cycle with a valid lui (`ExtImm`=0xABCD0000) in MEM. Requires a bubble (`RegWe`=0), `ExtImm_WB` unchanged, `stall_cnt`+1.
- Preload `retire_cnt` to all-ones with `CNT_W`=4 (15 retires), then retire one more. Requires `retire_cnt`=0. Then `rst` for one cycle: all outputs 0.
